// File: rtl/cache_pkg.sv
// Shared geometry and FSM encodings for the two-way write-through data cache.
package cache_pkg;

  localparam int SETS    = 64;
  localparam int TAG_W   = 11;
  localparam int IDX_LSB = 2;
  localparam int TAG_LSB = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2
  } state_e;

endpackage

// File: rtl/cache_storage.sv
// Valid/tag/data/lru arrays for a two-way set-associative cache with
// a combinational lookup and a single line/lru write port.
module cache_storage
  import cache_pkg::*;
#(
  parameter int SETS_P  = SETS,
  parameter int TAG_W_P = TAG_W,
  localparam int IDX_W  = $clog2(SETS_P)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IDX_W-1:0]   lookup_index,
  input  logic [TAG_W_P-1:0] lookup_tag,
  output logic               hit0,
  output logic               hit1,
  output logic [31:0]        data0,
  output logic [31:0]        data1,
  output logic               valid0,
  output logic               valid1,
  output logic               lru,
  input  logic               wr_en,
  input  logic               wr_way,
  input  logic [IDX_W-1:0]   wr_index,
  input  logic [TAG_W_P-1:0] wr_tag,
  input  logic [31:0]        wr_data,
  input  logic               set_lru
);

  logic [SETS_P-1:0]  valid_r [2];
  logic [SETS_P-1:0]  lru_r;
  logic [TAG_W_P-1:0] tag_r   [2][SETS_P];
  logic [31:0]        data_r  [2][SETS_P];

  // Valid and lru bits clear asynchronously; lru names the least-recently-used way.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r[0] <= '0;
      valid_r[1] <= '0;
      lru_r      <= '0;
    end else begin
      if (wr_en) begin
        valid_r[wr_way][wr_index] <= 1'b1;
      end
      if (set_lru) begin
        lru_r[wr_index] <= ~wr_way;
      end
    end
  end

  // Tag and data payload need no reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_r[wr_way][wr_index]  <= wr_tag;
      data_r[wr_way][wr_index] <= wr_data;
    end
  end

  assign valid0 = valid_r[0][lookup_index];
  assign valid1 = valid_r[1][lookup_index];
  assign lru    = lru_r[lookup_index];
  assign data0  = data_r[0][lookup_index];
  assign data1  = data_r[1][lookup_index];
  assign hit0   = valid0 && (tag_r[0][lookup_index] == lookup_tag);
  assign hit1   = valid1 && (tag_r[1][lookup_index] == lookup_tag);

endmodule

// File: rtl/cache_controller.sv
// Two-way write-through, no-write-allocate cache: FSM, victim choice and
// output muxing in front of the SRAM controller.
module cache_controller
  import cache_pkg::*;
#(
  parameter int SETS  = cache_pkg::SETS,
  parameter int TAG_W = cache_pkg::TAG_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  input  logic [31:0] sram_rdata,
  input  logic        sram_ready
);

  localparam int IDX_W = $clog2(SETS);

  state_e             state_r, next_state_s;
  logic [IDX_W-1:0]   index_s;
  logic [TAG_W-1:0]   tag_s;
  logic               hit0_s, hit1_s, hit_s, valid0_s, valid1_s, lru_s, victim_s;
  logic [31:0]        data0_s, data1_s, hit_data_s;
  logic               wr_en_s, wr_way_s, set_lru_s;
  logic [31:0]        wr_data_s;

  assign index_s    = address[IDX_LSB +: IDX_W];
  assign tag_s      = address[TAG_LSB +: TAG_W];
  assign hit_s      = hit0_s || hit1_s;
  assign hit_data_s = hit1_s ? data1_s : data0_s;
  // Fill empty ways first, way0 before way1, then evict the LRU way.
  assign victim_s   = !valid0_s ? 1'b0 : (!valid1_s ? 1'b1 : lru_s);

  cache_storage #(.SETS_P(SETS), .TAG_W_P(TAG_W)) u_storage (
    .clk          (clk),
    .rst          (rst),
    .lookup_index (index_s),
    .lookup_tag   (tag_s),
    .hit0         (hit0_s),
    .hit1         (hit1_s),
    .data0        (data0_s),
    .data1        (data1_s),
    .valid0       (valid0_s),
    .valid1       (valid1_s),
    .lru          (lru_s),
    .wr_en        (wr_en_s),
    .wr_way       (wr_way_s),
    .wr_index     (index_s),
    .wr_tag       (tag_s),
    .wr_data      (wr_data_s),
    .set_lru      (set_lru_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; a write takes priority over a simultaneous read.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (mem_w_en) begin
          next_state_s = WR_THRU;
        end else if (mem_r_en && !hit_s) begin
          next_state_s = RD_MISS;
        end else begin
          next_state_s = IDLE;
        end
      end
      RD_MISS, WR_THRU: begin
        if (sram_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = state_r;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Output and storage-write decode; SRAM enables depend on state only.
  always_comb begin
    rdata        = 32'h0;
    ready        = 1'b1;
    sram_address = 32'h0;
    sram_wdata   = 32'h0;
    sram_rd_en   = 1'b0;
    sram_wr_en   = 1'b0;
    wr_en_s      = 1'b0;
    wr_way_s     = hit1_s;
    wr_data_s    = wdata;
    set_lru_s    = 1'b0;
    case (state_r)
      IDLE: begin
        ready = !(mem_w_en || (mem_r_en && !hit_s));
        if (mem_r_en && !mem_w_en && hit_s) begin
          rdata     = hit_data_s;
          set_lru_s = 1'b1;
        end else begin
          rdata     = 32'h0;
          set_lru_s = 1'b0;
        end
      end
      RD_MISS: begin
        sram_rd_en   = 1'b1;
        sram_address = address;
        ready        = sram_ready;
        rdata        = sram_ready ? sram_rdata : 32'h0;
        wr_way_s     = victim_s;
        wr_data_s    = sram_rdata;
        wr_en_s      = sram_ready;
        set_lru_s    = sram_ready;
      end
      WR_THRU: begin
        sram_wr_en   = 1'b1;
        sram_address = address;
        sram_wdata   = wdata;
        ready        = sram_ready;
        wr_en_s      = sram_ready && hit_s;
        set_lru_s    = sram_ready && hit_s;
      end
      default: begin
        ready = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a fixed-latency SRAM responder.
module tb_cache_controller;
  import cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en, mem_w_en;
  logic [31:0] address, wdata, rdata;
  logic        ready;
  logic [31:0] sram_address, sram_wdata, sram_rdata;
  logic        sram_rd_en, sram_wr_en, sram_ready;
  logic [31:0] sram_val;
  logic        resp_cnt_r;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  cache_controller dut (
    .clk          (clk),
    .rst          (rst),
    .mem_r_en     (mem_r_en),
    .mem_w_en     (mem_w_en),
    .address      (address),
    .wdata        (wdata),
    .rdata        (rdata),
    .ready        (ready),
    .sram_address (sram_address),
    .sram_wdata   (sram_wdata),
    .sram_rd_en   (sram_rd_en),
    .sram_wr_en   (sram_wr_en),
    .sram_rdata   (sram_rdata),
    .sram_ready   (sram_ready)
  );

  // SRAM responder: two cycles of enable, then a one-cycle ready pulse.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_cnt_r <= 1'b0;
      sram_ready <= 1'b0;
    end else if (sram_ready) begin
      sram_ready <= 1'b0;
      resp_cnt_r <= 1'b0;
    end else if (sram_rd_en || sram_wr_en) begin
      if (resp_cnt_r) sram_ready <= 1'b1;
      else            resp_cnt_r <= 1'b1;
    end
  end

  assign sram_rdata = sram_ready ? sram_val : 32'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Read request; a miss must take SRAM latency (2) plus one cycle.
  task automatic rd(input logic [31:0] addr, input logic miss, input logic [31:0] exp);
    int n;
    @(negedge clk);
    address = addr; mem_r_en = 1'b1; sram_val = exp;
    #1;
    if (!miss) begin
      check_eq("hit_ready", {31'h0, ready}, 32'h1);
      check_eq("hit_rdata", rdata, exp);
      check_eq("hit_no_sram_rd", {31'h0, sram_rd_en}, 32'h0);
    end else begin
      check_eq("miss_ready_low", {31'h0, ready}, 32'h0);
      n = 0;
      while (!ready && n < 20) begin
        @(negedge clk); #1; n++;
      end
      check_eq("miss_latency", n, 32'd3);
      check_eq("miss_rdata", rdata, exp);
      check_eq("miss_sram_addr", sram_address, addr);
      check_eq("miss_sram_rd_en", {31'h0, sram_rd_en}, 32'h1);
    end
    @(negedge clk);
    mem_r_en = 1'b0;
    #1;
    check_eq("rd_en_dropped", {31'h0, sram_rd_en}, 32'h0);
  endtask

  // Write request, optionally with mem_r_en also high.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic both);
    int n;
    @(negedge clk);
    address = addr; wdata = data; mem_w_en = 1'b1; mem_r_en = both;
    #1;
    check_eq("wr_ready_low", {31'h0, ready}, 32'h0);
    n = 0;
    while (!ready && n < 20) begin
      @(negedge clk); #1; n++;
      check_eq("wr_no_sram_rd", {31'h0, sram_rd_en}, 32'h0);
    end
    check_eq("wr_latency", n, 32'd3);
    check_eq("wr_sram_wr_en", {31'h0, sram_wr_en}, 32'h1);
    check_eq("wr_sram_wdata", sram_wdata, data);
    check_eq("wr_sram_addr", sram_address, addr);
    @(negedge clk);
    mem_w_en = 1'b0; mem_r_en = 1'b0;
    #1;
    check_eq("wr_en_dropped", {31'h0, sram_wr_en}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0;
    address = 32'h0; wdata = 32'h0; sram_val = 32'h0;
    #12;
    check_eq("rst_ready", {31'h0, ready}, 32'h1);
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_sram_en", {30'h0, sram_rd_en, sram_wr_en}, 32'h0);
    check_eq("rst_sram_addr", sram_address, 32'h0);
    check_eq("rst_sram_wdata", sram_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Cold miss then immediate hit.
    rd(32'h0000_0104, 1'b1, 32'hDEAD_BEEF);
    rd(32'h0000_0104, 1'b0, 32'hDEAD_BEEF);

    // Three tags in set 1: third fill evicts way0 (0x104).
    rd(32'h0000_4104, 1'b1, 32'h1111_1111);
    rd(32'h0000_8104, 1'b1, 32'h2222_2222);
    rd(32'h0000_4104, 1'b0, 32'h1111_1111);
    rd(32'h0000_8104, 1'b0, 32'h2222_2222);
    rd(32'h0000_0104, 1'b1, 32'h3333_3333);
    rd(32'h0000_4104, 1'b1, 32'h5555_5555);

    // Write hit updates the cached line.
    wr(32'h0000_0104, 32'h1234_5678, 1'b0);
    rd(32'h0000_0104, 1'b0, 32'h1234_5678);

    // Write miss does not allocate.
    wr(32'h0000_0200, 32'hA5A5_5A5A, 1'b0);
    rd(32'h0000_0200, 1'b1, 32'h4444_4444);
    rd(32'h0000_0200, 1'b0, 32'h4444_4444);

    // Reset in the middle of a read miss.
    @(negedge clk);
    address = 32'h0000_0300; mem_r_en = 1'b1; sram_val = 32'h6666_6666;
    @(negedge clk); #1;
    check_eq("mid_rd_en", {31'h0, sram_rd_en}, 32'h1);
    mem_r_en = 1'b0; rst = 1'b1;
    #1;
    check_eq("abort_rd_en", {31'h0, sram_rd_en}, 32'h0);
    check_eq("abort_ready", {31'h0, ready}, 32'h1);
    check_eq("abort_sram_addr", sram_address, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rd(32'h0000_0300, 1'b1, 32'h7777_7777);
    rd(32'h0000_0104, 1'b1, 32'h8888_8888);

    // Both enables high: write-through path, line updated on hit.
    wr(32'h0000_0300, 32'hCAFE_F00D, 1'b1);
    rd(32'h0000_0300, 1'b0, 32'hCAFE_F00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
# cache_controller

Two-way set-associative, write-through, no-write-allocate data cache between the pipeline's memory stage and `sram_controller`. It answers read hits combinationally, forwards read misses and all writes to the SRAM controller, and freezes the pipeline through `ready` until each SRAM transaction finishes. On a read miss it fills the line with the returned word.

## Interface
Parameters:
- `SETS`, 64: number of sets; index = `address[7:2]`.
- `TAG_W`, 11: tag width; tag = `address[18:8]`.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `mem_r_en`  in  1  read request from the memory stage.
- `mem_w_en`  in  1  write request from the memory stage.
- `address`  in  32  byte address; bits [1:0] ignored, bits [31:19] ignored.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data; valid when `ready`=1 and `mem_r_en`=1.
- `ready`  out  1  request complete or no request; pipeline freeze = ~`ready`.
- `sram_address`  out  32  equals `address` while a transaction is open, else 0.
- `sram_wdata`  out  32  equals `wdata` while a write is open, else 0.
- `sram_rd_en`  out  1  SRAM read request, held until `sram_ready`.
- `sram_wr_en`  out  1  SRAM write request, held until `sram_ready`.
- `sram_rdata`  in  32  SRAM read data, valid with `sram_ready`.
- `sram_ready`  in  1  one-cycle SRAM completion pulse.

## Operation
- Storage per set: two ways, each {valid, tag[TAG_W], data[32]}, plus one `lru` bit naming the least-recently-used way.
- Hit in way w: valid[w] and tag[w] == `address[18:8]`. Both ways hitting cannot occur.
- States: IDLE, RD_MISS, WR_THRU.
- IDLE, no request: `ready`=1, `rdata`=0, SRAM enables 0.
- IDLE, read hit: `ready`=1, `rdata`=hit way data; `lru` <= ~w at the edge; stay IDLE.
- IDLE, read miss: `ready`=0; next state RD_MISS.
- IDLE, `mem_w_en`: `ready`=0; next state WR_THRU. A write wins if both enables are high. That input is illegal, but this is the defined behaviour.
- RD_MISS: `sram_rd_en`=1; addresses driven. When `sram_ready`=1: `ready`=1, `rdata`=`sram_rdata`. At the edge, write the victim way with {1, tag, `sram_rdata`}, set `lru` <= ~victim, and go to IDLE.
- Victim selection: way0 if !valid0, else way1 if !valid1, else `lru`.
- WR_THRU: `sram_wr_en`=1 and `sram_wdata`=`wdata`. When `sram_ready`=1: `ready`=1. On a hit, the hit way's data <= `wdata` and `lru` <= ~w. On a miss the cache is unchanged. Next state IDLE.
- SRAM enables are decoded from state only. They drop in the cycle after `sram_ready`, so the SRAM controller never sees a stale request in its idle state.
- The request inputs must stay stable while `ready`=0. The block does not latch them.

## Timing
- Read hit: zero wait cycles; `rdata` is combinational from the arrays.
- Read miss and write: `ready` low from the request cycle until the cycle `sram_ready` is high. Added latency equals the SRAM controller latency plus one cycle for the IDLE→RD_MISS/WR_THRU transition.
- Back-to-back requests: a new request is evaluated in the IDLE cycle that follows completion.
- Reset (async, any state): state goes to IDLE; all valid and `lru` bits clear to 0 and data arrays need not be cleared. Outputs settle to `ready`=1 with no request, `rdata`=0, SRAM enables 0, `sram_address`=0, `sram_wdata`=0.
- Reset during RD_MISS or WR_THRU aborts the transaction and no fill occurs. The SRAM controller shares `rst` and resets with it.
- `sram_ready` while in IDLE is ignored.

## Structure
- Shared package `cache_pkg`: `SETS`, `TAG_W`, index/tag bit positions, state encodings IDLE=0, RD_MISS=1, WR_THRU=2.
- Sub-module `cache_storage` holds the valid, tag, data and lru arrays. It has an async clear of valid and lru, a combinational lookup returning hit0, hit1 and the two data words, and a single write port taking {way, index, tag, data, set_lru}.
- `cache_controller` holds the FSM, victim selection and output muxing.

## Test plan
- Cold read of 0x0000_0104 with the SRAM model returning 0xDEADBEEF: `ready` low until `sram_ready`, then `rdata`=0xDEADBEEF. An immediate reread hits with `ready`=1 in the same cycle and `sram_rd_en` stays 0.
- Read fills of 0x104, then 0x4104, then 0x8104 (same set, three tags) force the third fill into way0, since way0 is the LRU. A following read of 0x4104 hits and a read of 0x104 misses.
- Write 0x1234_5678 to 0x104 after it is cached: `sram_wr_en` held until `sram_ready`, and a later read of 0x104 hits with `rdata`=0x12345678.
- Write to uncached 0x200: SRAM write issued, and a later read of 0x200 misses, confirming no allocate.
- Reset asserted mid RD_MISS: `sram_rd_en` drops at once and `ready`=1. A later read of the same address misses.
- `mem_r_en` and `mem_w_en` both high: the block takes the WR_THRU path and `sram_rd_en` stays 0.
